// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl
//   Sequencer between the RV32IM execute stage and the multi-cycle MUL/DIV/REM
//   unit. It takes one M-op at a time, launches it with a single-cycle pulse,
//   refuses results that arrive before the minimum latency for that op class,
//   abandons ops that never complete, and hands results to writeback over a
//   valid/ready handshake.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   req_valid_i/op/ra/rb/rd  decoded M-op from the pipeline
//   req_ready_o              controller idle, a request will be taken
//   flush_i                  kill the in-flight op (unit is left to finish)
//   stall_o                  hold the pipeline while an op is live
//   md_valid_o/op/ra/rb      issue pulse and latched operands to the unit
//   md_ready_i, md_result_i  unit completion and result
//   wb_valid_o/rd/result     result offered to writeback
//   wb_ready_i               writeback takes the result
//   busy_rd_o                rd of the live, unkilled op (0 when none)
//   err_timeout_o            sticky: an op was abandoned on timeout
//   err_proto_o              sticky: unit signalled ready too early

module muldiv_issue_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 32,
   parameter int TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic [2:0]  req_op_i,
   input  logic [31:0] req_ra_i,
   input  logic [31:0] req_rb_i,
   input  logic [4:0]  req_rd_i,
   output logic        req_ready_o,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        md_valid_o,
   output logic [2:0]  md_op_o,
   output logic [31:0] md_ra_o,
   output logic [31:0] md_rb_o,
   input  logic        md_ready_i,
   input  logic [31:0] md_result_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_result_o,
   input  logic        wb_ready_i,
   output logic [4:0]  busy_rd_o,
   output logic        err_timeout_o,
   output logic        err_proto_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          kill;
   logic [4:0]    rd;

   logic [CW-1:0] min_lat;
   logic          hit;
   logic          dead;

   // op[2] separates the divide/remainder class from the multiply class
   assign min_lat = md_op_o[2] ? CW'(DIV_LAT) : CW'(MUL_LAT);
   assign hit     = md_ready_i && (cnt >= min_lat);
   // a flush in the same cycle as the result counts as already killed
   assign dead    = kill || flush_i;

   assign req_ready_o = (state == IDLE);
   assign stall_o     = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         cnt           <= '0;
         kill          <= 1'b0;
         rd            <= '0;
         md_valid_o    <= 1'b0;
         md_op_o       <= '0;
         md_ra_o       <= '0;
         md_rb_o       <= '0;
         wb_valid_o    <= 1'b0;
         wb_rd_o       <= '0;
         wb_result_o   <= '0;
         busy_rd_o     <= '0;
         err_timeout_o <= 1'b0;
         err_proto_o   <= 1'b0;
      end else begin
         md_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i && !flush_i) begin
                  md_op_o    <= req_op_i;
                  md_ra_o    <= req_ra_i;
                  md_rb_o    <= req_rb_i;
                  rd         <= req_rd_i;
                  busy_rd_o  <= req_rd_i;
                  kill       <= 1'b0;
                  cnt        <= '0;
                  md_valid_o <= 1'b1;
                  state      <= ISSUE;
               end
            end

            ISSUE: begin
               // the launch pulse still goes out on a flush; only the result is dropped
               cnt   <= CW'(1);
               state <= WAIT;
               if (flush_i) begin
                  kill      <= 1'b1;
                  busy_rd_o <= '0;
               end
               // cnt is 0 here, so any ready is premature
               if (md_ready_i) err_proto_o <= 1'b1;
            end

            WAIT: begin
               if (flush_i) begin
                  kill      <= 1'b1;
                  busy_rd_o <= '0;
               end
               if (hit) begin
                  if (dead || rd == '0) begin
                     busy_rd_o <= '0;
                     state     <= IDLE;
                  end else begin
                     wb_valid_o  <= 1'b1;
                     wb_rd_o     <= rd;
                     wb_result_o <= md_result_i;
                     state       <= WB;
                  end
               end else begin
                  if (md_ready_i) err_proto_o <= 1'b1;
                  // leaving at TIMEOUT is what keeps cnt from wrapping
                  if (cnt == CW'(TIMEOUT)) begin
                     err_timeout_o <= 1'b1;
                     busy_rd_o     <= '0;
                     state         <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            WB: begin
               // flush takes priority over a simultaneous handshake
               if (flush_i || wb_ready_i) begin
                  wb_valid_o <= 1'b0;
                  busy_rd_o  <= '0;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a writeback scoreboard.
module tb_muldiv_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_ra, req_rb;
   logic [4:0]  req_rd;
   logic        req_ready_o;
   logic        flush;
   logic        stall_o;
   logic        md_valid_o;
   logic [2:0]  md_op_o;
   logic [31:0] md_ra_o, md_rb_o;
   logic        md_ready;
   logic [31:0] md_result;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_result_o;
   logic        wb_ready;
   logic [4:0]  busy_rd_o;
   logic        err_timeout_o, err_proto_o;

   muldiv_issue_ctrl #(.MUL_LAT(2), .DIV_LAT(32), .TIMEOUT(64)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_op_i(req_op), .req_ra_i(req_ra),
      .req_rb_i(req_rb), .req_rd_i(req_rd), .req_ready_o(req_ready_o),
      .flush_i(flush), .stall_o(stall_o),
      .md_valid_o(md_valid_o), .md_op_o(md_op_o), .md_ra_o(md_ra_o),
      .md_rb_o(md_rb_o), .md_ready_i(md_ready), .md_result_i(md_result),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
      .wb_ready_i(wb_ready), .busy_rd_o(busy_rd_o),
      .err_timeout_o(err_timeout_o), .err_proto_o(err_proto_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] res;
   } wb_t;

   wb_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RV32M reference results
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      logic [63:0] u;
      case (op)
         3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
         3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
         3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
         3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hffff_ffff;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // One clock: scoreboard check just before the edge, then step to 1ns after it.
   task automatic cyc();
      wb_t e;
      @(negedge clk);
      if (wb_valid_o) chk("wb_expected", 32'(exp_q.size() != 0), 1);
      if (wb_valid_o && wb_ready && !flush && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("sb_rd", 32'(wb_rd_o), 32'(e.rd));
         chk("sb_result", wb_result_o, e.res);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   // Present a request for one cycle; returns in the issue cycle.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
      req_valid = 1'b1; req_op = op; req_ra = a; req_rb = b; req_rd = rd;
      cyc();
      req_valid = 1'b0; req_op = 3'd0; req_ra = '0; req_rb = '0; req_rd = '0;
      chk("issue_pulse", 32'(md_valid_o), 1);
      chk("issue_op", 32'(md_op_o), 32'(op));
      chk("issue_ra", md_ra_o, a);
      chk("issue_rb", md_rb_o, b);
      chk("issue_stall", 32'(stall_o), 1);
      chk("issue_ready", 32'(req_ready_o), 0);
      chk("issue_busy_rd", 32'(busy_rd_o), 32'(rd));
   endtask

   task automatic reset_state(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready_o), 1);
      chk({tag, "_stall"}, 32'(stall_o), 0);
      chk({tag, "_md_valid"}, 32'(md_valid_o), 0);
      chk({tag, "_md_op"}, 32'(md_op_o), 0);
      chk({tag, "_md_ra"}, md_ra_o, 0);
      chk({tag, "_md_rb"}, md_rb_o, 0);
      chk({tag, "_wb_valid"}, 32'(wb_valid_o), 0);
      chk({tag, "_wb_rd"}, 32'(wb_rd_o), 0);
      chk({tag, "_wb_result"}, wb_result_o, 0);
      chk({tag, "_busy_rd"}, 32'(busy_rd_o), 0);
      chk({tag, "_err_timeout"}, 32'(err_timeout_o), 0);
      chk({tag, "_err_proto"}, 32'(err_proto_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_ra = '0; req_rb = '0; req_rd = '0;
      flush = 1'b0; md_ready = 1'b0; md_result = '0; wb_ready = 1'b0;
      #1;
      reset_state("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      reset_state("post_rst");

      // MUL 7*6 rd=5, ready at issue+2
      exp_q.push_back(wb_t'{rd: 5'd5, res: model(3'd0, 32'd7, 32'd6)});
      send(3'd0, 32'd7, 32'd6, 5'd5);
      cyc();
      chk("mul_pulse_once", 32'(md_valid_o), 0);
      chk("mul_no_wb_early", 32'(wb_valid_o), 0);
      cyc();
      md_ready = 1'b1; md_result = 32'd42;
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("mul_wb_valid", 32'(wb_valid_o), 1);
      chk("mul_wb_rd", 32'(wb_rd_o), 5);
      chk("mul_wb_result", wb_result_o, 42);
      chk("mul_stall_wb", 32'(stall_o), 1);
      wb_ready = 1'b1;
      cyc();
      wb_ready = 1'b0;
      chk("mul_done_valid", 32'(wb_valid_o), 0);
      chk("mul_done_ready", 32'(req_ready_o), 1);
      chk("mul_done_stall", 32'(stall_o), 0);
      chk("mul_done_busy", 32'(busy_rd_o), 0);
      chk("mul_op_held", 32'(md_op_o), 0);
      chk("mul_ra_held", md_ra_o, 7);

      // DIVU 100/7 rd=3, ready at issue+32, writeback backpressured 3 cycles
      exp_q.push_back(wb_t'{rd: 5'd3, res: model(3'd5, 32'd100, 32'd7)});
      send(3'd5, 32'd100, 32'd7, 5'd3);
      cycles(31);
      chk("divu_stall", 32'(stall_o), 1);
      chk("divu_no_wb", 32'(wb_valid_o), 0);
      cyc();
      md_ready = 1'b1; md_result = 32'd14;
      cyc();
      md_ready = 1'b0; md_result = '0;
      for (int i = 0; i < 3; i++) begin
         chk("divu_hold_valid", 32'(wb_valid_o), 1);
         chk("divu_hold_rd", 32'(wb_rd_o), 3);
         chk("divu_hold_result", wb_result_o, 14);
         cyc();
      end
      chk("divu_still_valid", 32'(wb_valid_o), 1);
      wb_ready = 1'b1;
      cyc();
      wb_ready = 1'b0;
      chk("divu_release", 32'(wb_valid_o), 0);
      chk("divu_idle", 32'(req_ready_o), 1);
      chk("divu_no_proto", 32'(err_proto_o), 0);

      // DIV 63/7 rd=10, early ready at issue+10 then real one at issue+32
      exp_q.push_back(wb_t'{rd: 5'd10, res: model(3'd4, 32'd63, 32'd7)});
      send(3'd4, 32'd63, 32'd7, 5'd10);
      cycles(10);
      chk("div_proto_before", 32'(err_proto_o), 0);
      md_ready = 1'b1; md_result = 32'hdead_beef;
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("div_proto_set", 32'(err_proto_o), 1);
      chk("div_early_ignored", 32'(wb_valid_o), 0);
      chk("div_early_stall", 32'(stall_o), 1);
      cycles(21);
      md_ready = 1'b1; md_result = 32'd9; wb_ready = 1'b1;
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("div_wb_valid", 32'(wb_valid_o), 1);
      chk("div_wb_result", wb_result_o, 9);
      cyc();
      wb_ready = 1'b0;
      chk("div_done", 32'(wb_valid_o), 0);
      chk("div_proto_sticky", 32'(err_proto_o), 1);

      // MULH rd=9, flush at issue+1, ready at issue+2 -> discarded
      send(3'd1, 32'hffff_fffd, 32'd5, 5'd9);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_busy_clr", 32'(busy_rd_o), 0);
      chk("flush_stall", 32'(stall_o), 1);
      md_ready = 1'b1; md_result = model(3'd1, 32'hffff_fffd, 32'd5);
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("flush_idle", 32'(req_ready_o), 1);
      chk("flush_no_wb", 32'(wb_valid_o), 0);
      chk("flush_busy_idle", 32'(busy_rd_o), 0);
      cyc();

      // REM rd=4 never completes -> timeout
      send(3'd6, 32'd50, 32'd8, 5'd4);
      cycles(64);
      chk("to_stall_at_limit", 32'(stall_o), 1);
      chk("to_err_not_yet", 32'(err_timeout_o), 0);
      cyc();
      chk("to_err_set", 32'(err_timeout_o), 1);
      chk("to_idle", 32'(req_ready_o), 1);
      chk("to_busy_clr", 32'(busy_rd_o), 0);
      chk("to_no_wb", 32'(wb_valid_o), 0);

      // follow-up MUL 3*5 rd=6 completes normally
      exp_q.push_back(wb_t'{rd: 5'd6, res: model(3'd0, 32'd3, 32'd5)});
      send(3'd0, 32'd3, 32'd5, 5'd6);
      cycles(2);
      md_ready = 1'b1; md_result = 32'd15;
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("mul2_wb_valid", 32'(wb_valid_o), 1);
      wb_ready = 1'b1;
      cyc();
      wb_ready = 1'b0;
      chk("mul2_idle", 32'(req_ready_o), 1);
      chk("to_err_sticky", 32'(err_timeout_o), 1);

      // request with flush in the same cycle is ignored
      req_valid = 1'b1; req_op = 3'd0; req_ra = 32'd1; req_rb = 32'd1; req_rd = 5'd2; flush = 1'b1;
      cyc();
      req_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_no_issue", 32'(md_valid_o), 0);
      chk("idle_flush_ready", 32'(req_ready_o), 1);

      // flush in WB beats a simultaneous handshake
      exp_q.push_back(wb_t'{rd: 5'd7, res: model(3'd0, 32'd2, 32'd3)});
      send(3'd0, 32'd2, 32'd3, 5'd7);
      cycles(2);
      md_ready = 1'b1; md_result = 32'd6;
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("wbflush_valid", 32'(wb_valid_o), 1);
      wb_ready = 1'b1; flush = 1'b1;
      cyc();
      wb_ready = 1'b0; flush = 1'b0;
      chk("wbflush_dropped", 32'(wb_valid_o), 0);
      chk("wbflush_idle", 32'(req_ready_o), 1);
      chk("wbflush_pending", 32'(exp_q.size()), 1);
      exp_q.delete();

      // MULHU with rd=0 -> no writeback
      send(3'd3, 32'hffff_ffff, 32'd2, 5'd0);
      cycles(2);
      md_ready = 1'b1; md_result = model(3'd3, 32'hffff_ffff, 32'd2);
      cyc();
      md_ready = 1'b0; md_result = '0;
      chk("rd0_no_wb", 32'(wb_valid_o), 0);
      chk("rd0_idle", 32'(req_ready_o), 1);

      // DIV rd=8, reset mid-WAIT
      send(3'd4, 32'd80, 32'd9, 5'd8);
      cycles(9);
      chk("rstmid_busy", 32'(busy_rd_o), 8);
      rst_n = 1'b0;
      #1;
      reset_state("rst_mid");
      cycles(2);
      rst_n = 1'b1;
      md_ready = 1'b1; md_result = 32'd8;
      cycles(3);
      md_ready = 1'b0; md_result = '0;
      chk("rstmid_no_wb", 32'(wb_valid_o), 0);
      chk("rstmid_idle", 32'(req_ready_o), 1);
      chk("rstmid_no_issue", 32'(md_valid_o), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Sequencing controller between the RV32IM execute stage and the multi-cycle MUL/DIV/REM unit. It accepts one M-extension op at a time from the pipeline, issues it to the unit with a single-cycle launch pulse, and enforces minimum latencies of MUL_LAT for multiplies and DIV_LAT for divides. It stalls the pipeline while busy, captures the result, and hands it to writeback over a valid/ready handshake, with flush, rd=x0 and timeout handling.

Parameters:
MUL_LAT, 2, minimum cycles from issue pulse to an acceptable md_ready_i for op codes 0-3
DIV_LAT, 32, minimum cycles from issue pulse to an acceptable md_ready_i for op codes 4-7
TIMEOUT, 64, cycles after issue with no acceptable md_ready_i before the op is abandoned; must be greater than DIV_LAT

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  pipeline presents a decoded M-op
req_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_ra_i  in  32  rs1 value
req_rb_i  in  32  rs2 value
req_rd_i  in  5  destination register
req_ready_o  out  1  controller can accept a request
flush_i  in  1  kill the in-flight op
stall_o  out  1  pipeline hold
md_valid_o  out  1  one-cycle issue pulse to the unit
md_op_o  out  3  latched op code
md_ra_o  out  32  latched rs1 value
md_rb_o  out  32  latched rs2 value
md_ready_i  in  1  unit result valid
md_result_i  in  32  unit result
wb_valid_o  out  1  result available for writeback
wb_rd_o  out  5  destination register
wb_result_o  out  32  result
wb_ready_i  in  1  writeback accepts the result
busy_rd_o  out  5  rd of the live (unkilled) in-flight op; 0 otherwise (hazard check)
err_timeout_o  out  1  sticky: an op was abandoned on timeout
err_proto_o  out  1  sticky: md_ready_i seen before minimum latency

Behaviour:
- States IDLE, ISSUE, WAIT, WB. Reset (async, rst_ni=0) forces IDLE, clears all registers, the kill flag and both error flags. During and after reset: req_ready_o=1; all other outputs 0.
- Reset mid-operation: the pending op is discarded; no writeback.
- req_ready_o = (state==IDLE). stall_o = (state!=IDLE).
- IDLE: if req_valid_i & !flush_i, latch op, ra, rb and rd, then go to ISSUE. If flush_i is high in the same cycle, the request is ignored.
- ISSUE: md_valid_o=1 for exactly this cycle, with md_op_o/md_ra_o/md_rb_o driven from the latch. This cycle is cnt=0. Next state is WAIT.
- md_op_o/md_ra_o/md_rb_o hold their latched values until the next accept.
- WAIT: cnt increments by 1 each cycle, starting at 1. Width is $clog2(TIMEOUT+1); it never wraps.
  - min = MUL_LAT when op[2]=0, DIV_LAT when op[2]=1.
  - md_ready_i & cnt>=min: capture md_result_i. If killed or rd==0, go to IDLE; otherwise go to WB.
  - md_ready_i & cnt<min: ignore it and set err_proto_o.
  - cnt==TIMEOUT with no acceptable ready: set err_timeout_o and go to IDLE; no writeback.
- Earliest end-to-end timing: accept at T, issue at T+1, MUL ready accepted at T+3, wb_valid_o at T+4. For DIV, ready is accepted at T+33 and wb_valid_o rises at T+34.
- WB: wb_valid_o=1. wb_rd_o and wb_result_o are held stable until wb_ready_i. On handshake go to IDLE, with req_ready_o=1 the next cycle.
- flush_i in ISSUE or WAIT:
  - Set the kill flag and clear busy_rd_o.
  - The unit is not aborted: the controller keeps waiting for ready or timeout, then discards the result.
  - flush_i during ISSUE still emits the md_valid_o pulse.
- flush_i in WB: drop wb_valid_o and go to IDLE next cycle, even if wb_ready_i is high in that same cycle (flush wins).
- busy_rd_o = latched rd while in ISSUE/WAIT/WB and not killed; otherwise 0.
- Error flags clear only on reset.

Test Plan:
- MUL 7×6, rd=5, md_ready_i at issue+2 with result 42 -> wb_valid_o at accept+4 with wb_rd_o=5, wb_result_o=42; stall_o high from accept+1 through the handshake.
- DIVU 100/7, rd=3, md_ready_i at issue+32 with result 14 -> captured; wb_valid_o held 3 cycles under wb_ready_i=0; result and rd stable; released on wb_ready_i.
- DIV with md_ready_i pulsed at issue+10, then again at issue+32 with result 9 -> err_proto_o=1 after the early pulse; result 9 written back.
- MULH issued, flush_i at issue+1, md_ready_i at issue+2 -> busy_rd_o=0 from the next cycle; no wb_valid_o; req_ready_o=1 at issue+3.
- REM with md_ready_i never asserted -> err_timeout_o=1 at issue+64, back to IDLE; the next MUL request completes normally.
- MULHU with rd=0, then rst_ni pulsed low mid-WAIT of a following DIV -> no wb_valid_o for the rd=0 op; on reset the controller is in IDLE with all outputs 0 and req_ready_o=1.
